multiword_add_seq: RTL

//  Sequencer that feeds the 8-bit prefix adder one byte per cycle, LSB byte first.

---
 rtl/multiword_add_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: byte-serial multiword adder sequencer driving an external 8-bit adder.
// Define ADDSEQ_SUB_EN to add the op_sub port (two's-complement subtract a - b).
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               op_cin,
`ifdef ADDSEQ_SUB_EN
  input  logic               op_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] res_sum,
  output logic               res_cout,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout
);

  localparam int W  = 8 * WORDS;
  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  b_in;
  logic          c_in;
  logic          accept;
  logic          last;

`ifdef ADDSEQ_SUB_EN
  // Subtract is a + ~b + 1; the incoming carry is forced to one.
  assign b_in = op_sub ? ~op_b : op_b;
  assign c_in = op_sub ? 1'b1 : op_cin;
`else
  assign b_in = op_b;
  assign c_in = op_cin;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sh[7:0];
      add_b   = b_sh[7:0];
      add_cin = carry_q;
    end
  end

  // Each sum byte enters at the top, so after WORDS steps chunk 0 sits at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= b_in;
      carry_q <= c_in;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 8;
      b_sh    <= b_sh >> 8;
      res_sum <= W'({add_sum, res_sum} >> 8);
      carry_q <= add_cout;
      cnt     <= cnt + 1'b1;
      if (last) begin
        res_cout <= add_cout;
      end
    end
  end

endmodule
